store_narrow_buffer: RTL
========================

STORE_NARROW_BUFFER -- requirements
Module: store_narrow_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning number of buffered stores (power of two, >= 2).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port st_valid  input  1  meaning MEM stage presents a store.
REQ-005 The block SHALL have port st_ready  output  1  meaning buffer can accept; this is the pipeline stall source.
REQ-006 The block SHALL have port st_addr  input  32  meaning byte address of the store.
REQ-007 The block SHALL have port st_data  input  32  meaning register data; its low bits are narrowed.
REQ-008 The block SHALL have port st_size  input  2  meaning 00 byte, 01 half, 10 word, 11 treated as word.
REQ-009 The block SHALL have port mem_valid  output  1  meaning head entry presented to data memory.
REQ-010 The block SHALL have port mem_ready  input  1  meaning memory accepts head entry.
REQ-011 The block SHALL have port mem_addr  output  32  meaning word-aligned address {addr[31:2],2'b00}.
REQ-012 The block SHALL have port mem_wdata  output  32  meaning lane-replicated write data.
REQ-013 The block SHALL have port mem_be  output  4  meaning byte enables, bit i = byte lane i.
REQ-014 The block SHALL have port buf_empty  output  1  meaning no pending stores; used as load-ordering fence.
REQ-015 The block SHALL have port align_err  output  1  meaning one-cycle misalignment pulse.

Function
REQ-016 A store SHALL be accepted on a cycle where st_valid and st_ready are both 1.
REQ-017 st_ready SHALL equal not-full, registered-state only, with no combinational path from mem_ready.
REQ-018 Byte narrowing SHALL set wdata = {4{st_data[7:0]}} and be = 4'b0001 << st_addr[1:0].
REQ-019 Half narrowing SHALL set wdata = {2{st_data[15:0]}} and be = st_addr[1] ? 4'b1100 : 4'b0011.
REQ-020 Word narrowing (size 10 or 11) SHALL set wdata = st_data and be = 4'b1111.
REQ-021 An accepted store SHALL appear on mem_valid/mem_* no earlier than the next cycle (latency 1 when empty).
REQ-022 mem_valid SHALL equal not-empty; entries issue in FIFO order.
REQ-023 Handshake: the head is popped on mem_valid && mem_ready.
REQ-024 Handshake: mem_addr/mem_wdata/mem_be SHALL hold stable while mem_valid && !mem_ready.
REQ-025 Simultaneous push and pop SHALL keep the occupancy count unchanged, including when full; st_ready stays 0 that cycle when full.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH.
REQ-027 buf_empty SHALL be 1 exactly when occupancy is 0.

Reset
REQ-028 On rst_n low, pointers and count SHALL clear and all pending entries SHALL be discarded, including mid-handshake.
REQ-029 Reset values SHALL be: st_ready=1, mem_valid=0, buf_empty=1, align_err=0, mem_be=0.

Configuration
REQ-030 With STORE_ALIGN_CHECK_EN defined, half with addr[0]=1 or word with addr[1:0]!=0 SHALL be accepted but not enqueued.
REQ-031 With STORE_ALIGN_CHECK_EN defined, a misaligned store SHALL drive align_err high for exactly the cycle after acceptance.
REQ-032 Without STORE_ALIGN_CHECK_EN, no alignment check SHALL be made: misaligned addresses SHALL use the REQ-018..020 lane rules unchanged, and align_err SHALL be tied 0.

Structure
REQ-033 Package store_pkg SHALL hold the size encodings SZ_BYTE/SZ_HALF/SZ_WORD and the BE width constant.
REQ-034 Combinational narrowing (data replication, BE, misalignment flag) SHALL live in sub-module store_lane_gen; the buffer holds only registered state.

Verification
REQ-035 Bench: byte store addr 0x1003, data 0xAABBCCDD -> mem_addr 0x1000, wdata 0xDDDDDDDD, be 1000.
REQ-036 Bench: half store addr 0x2002, data 0x12345678 -> mem_addr 0x2000, wdata 0x56785678, be 1100.
REQ-037 Bench: mem_ready held 0 while 3 stores are offered (DEPTH=2) -> st_ready 0 after 2 accepted; mem_* stable; on release, issue order preserved.
REQ-038 Bench: full buffer with mem_ready=1 and st_valid=1 -> one pop per cycle, count steady after refill, no loss or duplication.
REQ-039 Bench: rst_n pulsed low while 2 entries are pending -> mem_valid 0 and buf_empty 1 immediately; no stale store after reset.
REQ-040 Bench: with macro, word store addr 0x3001 -> align_err pulses 1 cycle, no mem_valid; without macro -> be 1111, addr 0x3000.

Source files
------------

// File: rtl/store_pkg.sv
// Shared encodings and entry layout for the store narrowing buffer.
package store_pkg;

    localparam int unsigned BE_W = 4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Buffered store: word address, lane-replicated data and byte enables.
    typedef struct packed {
        logic [29:0]     waddr;
        logic [31:0]     wdata;
        logic [BE_W-1:0] be;
    } st_entry_t;

endpackage

// File: rtl/store_lane_gen.sv
// Combinational narrowing of a store: lane replication, byte enables and misalignment flag.
module store_lane_gen
    import store_pkg::*;
(
    input  logic [1:0]      addr_lo,
    input  logic [31:0]     data,
    input  logic [1:0]      size,
    output logic [31:0]     wdata,
    output logic [BE_W-1:0] be,
    output logic            misaligned
);

    always_comb begin
        wdata      = data;
        be         = '1;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                wdata = {4{data[7:0]}};
                be    = BE_W'(1) << addr_lo;
            end
            SZ_HALF: begin
                wdata      = {2{data[15:0]}};
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                misaligned = addr_lo[0];
            end
            // SZ_WORD and the reserved encoding 2'b11 both behave as a word
            default: begin
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/store_narrow_buffer.sv
// Store buffer between MEM stage and data memory with sub-word narrowing.
// Optional alignment checking is enabled by defining STORE_ALIGN_CHECK_EN.
module store_narrow_buffer
    import store_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            st_valid,
    output logic            st_ready,
    input  logic [31:0]     st_addr,
    input  logic [31:0]     st_data,
    input  logic [1:0]      st_size,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [31:0]     mem_addr,
    output logic [31:0]     mem_wdata,
    output logic [BE_W-1:0] mem_be,
    output logic            buf_empty,
    output logic            align_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    st_entry_t       fifo_q [DEPTH];
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   count_q, count_d;

    logic [31:0]     lane_wdata;
    logic [BE_W-1:0] lane_be;
    logic            lane_mis;
    logic            full, accept, push, pop;
    st_entry_t       head;

    store_lane_gen u_lane_gen (
        .addr_lo    (st_addr[1:0]),
        .data       (st_data),
        .size       (st_size),
        .wdata      (lane_wdata),
        .be         (lane_be),
        .misaligned (lane_mis)
    );

    // Ready depends only on registered occupancy, never on mem_ready
    assign full     = (count_q == CW'(DEPTH));
    assign st_ready = !full;
    assign accept   = st_valid && st_ready;

`ifdef STORE_ALIGN_CHECK_EN
    logic align_err_q;

    // Misaligned stores are consumed but dropped
    assign push      = accept && !lane_mis;
    assign align_err = align_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= accept && lane_mis;
        end
    end
`else
    logic unused_lane_mis;

    assign unused_lane_mis = lane_mis;
    assign push            = accept;
    assign align_err       = 1'b0;
`endif

    assign mem_valid = (count_q != '0);
    assign buf_empty = (count_q == '0);
    assign pop       = mem_valid && mem_ready;

    assign head      = fifo_q[rptr_q];
    assign mem_addr  = {head.waddr, 2'b00};
    assign mem_wdata = head.wdata;
    assign mem_be    = mem_valid ? head.be : '0;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointers are PW bits wide, so increments wrap modulo DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_q[wptr_q] <= '{waddr: st_addr[31:2], wdata: lane_wdata, be: lane_be};
                wptr_q         <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

endmodule
